// File: rtl/mdu_hilo.sv
// MIPS multiply/divide unit holding the architectural HI/LO registers.
// Multiplies complete after a fixed latency; divides use a radix-2 restoring loop.
module mdu_hilo #(
  parameter int MULT_LAT = 5,
  parameter int WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CNT_MAX = (WIDTH > MULT_LAT) ? WIDTH : MULT_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               setup_q, setup_d;
  logic               quotNeg_q, quotNeg_d;
  logic               remNeg_q, remNeg_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               mulSigned;
  logic               divSigned;
  logic [2*WIDTH-1:0] mulA;
  logic [2*WIDTH-1:0] mulB;
  logic [2*WIDTH-1:0] mulProd;
  logic [WIDTH+1:0]   remShift;
  logic [WIDTH+1:0]   trial;

  // Sign-extending to the full product width makes the truncated product
  // the correct two's-complement result for MULT as well as MULTU.
  always_comb begin
    mulSigned = (op == OP_MULT);
    divSigned = (op == OP_DIV);
    mulA      = mulSigned ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    mulB      = mulSigned ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    mulProd   = mulA * mulB;
    remShift  = {rem_q, quot_q[WIDTH-1]};
    trial     = remShift - {2'b00, divisor_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    divisor_d = divisor_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    setup_d   = setup_q;
    quotNeg_d = quotNeg_q;
    remNeg_d  = remNeg_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              product_d = mulProd;
              cnt_d     = MUL_CNT_INIT;
              state_d   = MUL;
            end
            OP_DIV, OP_DIVU: begin
              quot_d    = a;
              divisor_d = b;
              rem_d     = '0;
              divZero_d = (b == '0);
              quotNeg_d = divSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
              remNeg_d  = divSigned & a[WIDTH-1];
              setup_d   = 1'b1;
              state_d   = DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      MUL: begin
        if (cnt_q == '0) begin
          hi_d    = product_q[2*WIDTH-1:WIDTH];
          lo_d    = product_q[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // First DIV edge turns the raw operands into magnitudes; the sign of b
      // is recovered as quotNeg ^ remNeg, so no extra flag is kept.
      DIV: begin
        if (setup_q) begin
          quot_d    = remNeg_q ? -quot_q : quot_q;
          divisor_d = (quotNeg_q ^ remNeg_q) ? -divisor_q : divisor_q;
          cnt_d     = DIV_CNT_INIT;
          setup_d   = 1'b0;
        end else begin
          if (!trial[WIDTH+1]) begin
            rem_d  = trial[WIDTH:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d  = remShift[WIDTH:0];
            quot_d = {quot_q[WIDTH-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      FIX: begin
        if (!divZero_q) begin
          lo_d = quotNeg_q ? -quot_q : quot_q;
          hi_d = remNeg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      divisor_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      setup_q   <= 1'b0;
      quotNeg_q <= 1'b0;
      remNeg_q  <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      divisor_q <= divisor_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      setup_q   <= setup_d;
      quotNeg_q <= quotNeg_d;
      remNeg_q  <= remNeg_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: hand-computed HI/LO results, busy widths,
// done pulses, ignored requests while busy and mid-operation reset.
module tb_mdu_hilo;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] tbA;
  logic [31:0] tbB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors;
  int miscompares;
  int busyCycles;

  mdu_hilo #(.MULT_LAT(5), .WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (tbA),
    .b    (tbB),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; holds the request for exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] opV, input logic [31:0] aV,
                               input logic [31:0] bV);
    start = 1'b1;
    op    = opV;
    tbA   = aV;
    tbB   = bV;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
  endtask

  // Counts falling edges with busy high; bounded so a stuck unit still ends.
  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    op          = 3'd0;
    tbA         = '0;
    tbB         = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset hilo", {hi, lo}, 64'd0);

    // MULT -3 * 5
    applyStimulus(3'd1, 32'hFFFF_FFFD, 32'd5);
    waitIdle(busyCycles);
    checkOutput("mult busy width", 64'(busyCycles), 64'd5);
    checkOutput("mult done", 64'(done), 64'd1);
    checkOutput("mult hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clk);
    checkOutput("mult done single", 64'(done), 64'd0);

    // MULTU max * max, then MTLO issued in the done cycle
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitIdle(busyCycles);
    checkOutput("multu busy width", 64'(busyCycles), 64'd5);
    checkOutput("multu done", 64'(done), 64'd1);
    checkOutput("multu hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(3'd6, 32'h1234_5678, 32'd0);
    checkOutput("mtlo hilo", {hi, lo}, 64'hFFFF_FFFE_1234_5678);
    checkOutput("mtlo busy", 64'(busy), 64'd0);
    checkOutput("mtlo done", 64'(done), 64'd0);

    // op 7 is a no-op
    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd3);
    checkOutput("noop busy", 64'(busy), 64'd0);
    checkOutput("noop hilo", {hi, lo}, 64'hFFFF_FFFE_1234_5678);

    // DIV -7 / 2 and DIVU 100 / 7
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
    waitIdle(busyCycles);
    checkOutput("div busy width", 64'(busyCycles), 64'd34);
    checkOutput("div done", 64'(done), 64'd1);
    checkOutput("div hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(3'd4, 32'd100, 32'd7);
    waitIdle(busyCycles);
    checkOutput("divu busy width", 64'(busyCycles), 64'd34);
    checkOutput("divu hilo", {hi, lo}, {32'd2, 32'd14});

    // Divide by zero leaves preloaded HI/LO untouched
    applyStimulus(3'd5, 32'hAAAA_0000, 32'd0);
    applyStimulus(3'd6, 32'h0000_BBBB, 32'd0);
    checkOutput("preload hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);
    applyStimulus(3'd4, 32'd55, 32'd0);
    waitIdle(busyCycles);
    checkOutput("div0 busy width", 64'(busyCycles), 64'd34);
    checkOutput("div0 done", 64'(done), 64'd1);
    checkOutput("div0 hilo", {hi, lo}, 64'hAAAA_0000_0000_BBBB);

    // Signed overflow
    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(busyCycles);
    checkOutput("ovf busy width", 64'(busyCycles), 64'd34);
    checkOutput("ovf hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // DIV 100 / -7 with MTHI and MULT requests at busy cycles 3 and 10
    applyStimulus(3'd3, 32'd100, 32'hFFFF_FFF9);
    busyCycles = 0;
    while (busy && busyCycles < 200) begin
      busyCycles++;
      start = (busyCycles == 3) || (busyCycles == 10);
      op    = (busyCycles == 3) ? 3'd5 : 3'd1;
      tbA   = (busyCycles == 3) ? 32'hDEAD_BEEF : 32'd3;
      tbB   = 32'd4;
      @(negedge clk);
    end
    start = 1'b0;
    op    = 3'd0;
    checkOutput("ignored busy width", 64'(busyCycles), 64'd34);
    checkOutput("ignored done", 64'(done), 64'd1);
    checkOutput("ignored hilo", {hi, lo}, 64'h0000_0002_FFFF_FFF2);
    @(negedge clk);
    checkOutput("ignored stays idle", 64'(busy), 64'd0);

    // Reset at busy cycle 20 of a DIVU
    applyStimulus(3'd4, 32'd1000, 32'd3);
    busyCycles = 0;
    while (busy && busyCycles < 19) begin
      busyCycles++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst mid busy", 64'(busy), 64'd0);
    checkOutput("rst mid done", 64'(done), 64'd0);
    checkOutput("rst mid hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    checkOutput("rst no late done", 64'(done), 64'd0);

    // MULT 7 * -6 right after reset
    applyStimulus(3'd1, 32'd7, 32'hFFFF_FFFA);
    waitIdle(busyCycles);
    checkOutput("post rst busy width", 64'(busyCycles), 64'd5);
    checkOutput("post rst done", 64'(done), 64'd1);
    checkOutput("post rst hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
